run_controller: RTL

- Hardware run sequencer for the simple processor core. It replaces the fixed "reset, run N cycles, read output" flow with a parametrised, restartable controller.
- It holds the core in reset, releases it on `start`, and counts execution cycles against a programmable budget.
- It detects core halt and waits for the classification result to be stable before latching it.
- It reports done, timeout and cycle count to the host or bench. It sits between the host and the core's reset and result pins.

---
 rtl/run_controller.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/run_controller.sv
// Run sequencer for the processor core: holds the core in reset, releases it
// on start, counts RUN+SETTLE cycles against a budget, waits for a stable
// result after halt, and reports done / timed_out / result / cycles_used.
module run_controller #(
  parameter int DATA_W        = 8,
  parameter int CNT_W         = 16,
  parameter int RESET_CYCLES  = 1,
  parameter int MAX_CYCLES    = 20,
  parameter int STABLE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  cycle_budget,
  input  logic              core_halt,
  input  logic [DATA_W-1:0] core_result,
  output logic              core_reset,
  output logic              busy,
  output logic              done,
  output logic              timed_out,
  output logic [DATA_W-1:0] result,
  output logic [CNT_W-1:0]  cycles_used
);

  localparam int RC_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int SB_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [RC_W-1:0]  RC_LAST = RC_W'(RESET_CYCLES - 1);
  localparam logic [SB_W-1:0]  SB_FULL = SB_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] MAX_B   = CNT_W'(MAX_CYCLES);

  typedef enum logic [2:0] {S_IDLE, S_RESET, S_RUN, S_SETTLE, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  budget_q, budget_d;
  logic [RC_W-1:0]   rcnt_q, rcnt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] prev_q, prev_d;
  logic [SB_W-1:0]   stab_q, stab_d;
  logic              core_reset_q, core_reset_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              timed_out_q, timed_out_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [CNT_W-1:0]  cycles_q, cycles_d;
  logic              expire;

  // Budget expiry: cnt never passes B-1, so it cannot wrap.
  assign expire = (cnt_q == budget_q - CNT_W'(1));

  // Next-state and registered-output logic; outputs are derived from state_d
  // so they line up with the state they describe.
  always_comb begin
    state_d     = state_q;
    budget_d    = budget_q;
    rcnt_d      = rcnt_q;
    cnt_d       = cnt_q;
    prev_d      = prev_q;
    stab_d      = stab_q;
    timed_out_d = timed_out_q;
    result_d    = result_q;
    cycles_d    = cycles_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_RESET;
          budget_d    = (cycle_budget == '0) ? MAX_B : cycle_budget;
          timed_out_d = 1'b0;
          rcnt_d      = '0;
        end
      end
      S_RESET: begin
        if (rcnt_q == RC_LAST) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          rcnt_d = rcnt_q + RC_W'(1);
        end
      end
      S_RUN, S_SETTLE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (abort) begin
          state_d = S_IDLE;
        end else if (expire) begin
          state_d     = S_DONE;
          timed_out_d = 1'b1;
          result_d    = core_result;
          cycles_d    = budget_q;
        end else if (state_q == S_RUN) begin
          if (core_halt) begin
            if (STABLE_CYCLES == 1) begin
              state_d  = S_DONE;
              result_d = core_result;
              cycles_d = cnt_q + CNT_W'(1);
            end else begin
              state_d = S_SETTLE;
              prev_d  = core_result;
              stab_d  = SB_W'(1);
            end
          end
        end else begin
          // Halt is sticky here: only result stability matters.
          if (core_result == prev_q) begin
            stab_d = stab_q + SB_W'(1);
            if (stab_q + SB_W'(1) == SB_FULL) begin
              state_d  = S_DONE;
              result_d = core_result;
              cycles_d = cnt_q + CNT_W'(1);
            end
          end else begin
            prev_d = core_result;
            stab_d = SB_W'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    core_reset_d = !((state_d == S_RUN) || (state_d == S_SETTLE));
    busy_d       = (state_d != S_IDLE);
    done_d       = (state_d == S_DONE);
  end

  // State and output registers; async reset holds the core in reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      budget_q     <= '0;
      rcnt_q       <= '0;
      cnt_q        <= '0;
      prev_q       <= '0;
      stab_q       <= '0;
      core_reset_q <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      timed_out_q  <= 1'b0;
      result_q     <= '0;
      cycles_q     <= '0;
    end else begin
      state_q      <= state_d;
      budget_q     <= budget_d;
      rcnt_q       <= rcnt_d;
      cnt_q        <= cnt_d;
      prev_q       <= prev_d;
      stab_q       <= stab_d;
      core_reset_q <= core_reset_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      timed_out_q  <= timed_out_d;
      result_q     <= result_d;
      cycles_q     <= cycles_d;
    end
  end

  assign core_reset  = core_reset_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timed_out   = timed_out_q;
  assign result      = result_q;
  assign cycles_used = cycles_q;

endmodule
